// File: rtl/ddr_avl_gate_pkg.sv
// ddr_avl_gate_pkg: shared types and constants for the DDR Avalon traffic gate.
//   gate_state_e : gate FSM states (OFFLINE, ONLINE, FLUSH)
//   FLUSH_DATA   : read data returned on synthesized (flushed) beats, all zeros
//   pend_width() : width of the outstanding-read counter, $clog2(MAX_PEND+1)
package ddr_avl_gate_pkg;

  typedef enum logic [1:0] {
    OFFLINE = 2'd0,
    ONLINE  = 2'd1,
    FLUSH   = 2'd2
  } gate_state_e;

  // Wide enough for any practical DATA_W; users slice [DATA_W-1:0].
  localparam int FLUSH_DATA_MAX_W = 1024;
  localparam logic [FLUSH_DATA_MAX_W-1:0] FLUSH_DATA = '0;

  function automatic int pend_width(input int max_pend);
    return $clog2(max_pend + 1);
  endfunction

endpackage

// File: rtl/ddr_avl_gate_if.sv
// ddr_avl_gate_if: user-side and controller-side Avalon signals of the gate.
//   slave  modport : the gate's view (user command in, controller command out)
//   master modport : the environment's view (user master + DDR controller)
// Handshake: a user command/write beat is transferred in a cycle where
// us_read or us_write is high and us_waitrequest is low; a controller
// command/write beat is transferred where avl_read_req or avl_write_req is
// high and avl_ready is high; a read beat is transferred in every cycle its
// *_valid is high (no back-pressure on read data).
interface ddr_avl_gate_if #(
  parameter int ADDR_W  = 25,
  parameter int DATA_W  = 64,
  parameter int BURST_W = 4
);
  logic [ADDR_W-1:0]   us_address;
  logic                us_read;
  logic                us_write;
  logic [DATA_W-1:0]   us_writedata;
  logic [DATA_W/8-1:0] us_byteenable;
  logic [BURST_W-1:0]  us_burstcount;
  logic                us_waitrequest;
  logic [DATA_W-1:0]   us_readdata;
  logic                us_readdatavalid;
  logic                us_response_err;

  logic [ADDR_W-1:0]   avl_addr;
  logic                avl_read_req;
  logic                avl_write_req;
  logic [DATA_W-1:0]   avl_wdata;
  logic [DATA_W/8-1:0] avl_be;
  logic [BURST_W-1:0]  avl_size;
  logic                avl_ready;
  logic [DATA_W-1:0]   avl_rdata;
  logic                avl_rdata_valid;

  modport slave (
    input  us_address, us_read, us_write, us_writedata, us_byteenable, us_burstcount,
    output us_waitrequest, us_readdata, us_readdatavalid, us_response_err,
    output avl_addr, avl_read_req, avl_write_req, avl_wdata, avl_be, avl_size,
    input  avl_ready, avl_rdata, avl_rdata_valid
  );

  modport master (
    output us_address, us_read, us_write, us_writedata, us_byteenable, us_burstcount,
    input  us_waitrequest, us_readdata, us_readdatavalid, us_response_err,
    input  avl_addr, avl_read_req, avl_write_req, avl_wdata, avl_be, avl_size,
    output avl_ready, avl_rdata, avl_rdata_valid
  );
endinterface

// File: rtl/ddr_avl_watchdog.sv
// ddr_avl_watchdog: read-response timer.
//   clk, reset_n : clock, asynchronous active-low reset
//   run          : count this cycle (reads pending while online)
//   kick         : a read beat arrived; restart the count
//   clr          : force the count to zero
//   expire       : one-cycle pulse when the count reaches TIMEOUT-1
module ddr_avl_watchdog #(
  parameter int TIMEOUT = 1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  input  logic kick,
  input  logic clr,
  output logic expire
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    expire = 1'b0;
    if (clr || kick) begin
      cnt_d = '0;
    end else if (run) begin
      if (cnt_q == LAST) begin
        expire = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
endmodule

// File: rtl/ddr_avl_gate.sv
// ddr_avl_gate: gates user Avalon traffic to the DDR controller on the reset
// sequencer's ready, flushes outstanding reads when memory is lost, and
// requests recalibration when read responses stop arriving.
//   clk, reset_n      : clock, asynchronous active-low reset
//   ready             : memory ready from the reset sequencer
//   bus               : user + controller Avalon signals (ddr_avl_gate_if.slave)
//   online            : high while commands pass through
//   err_timeout       : sticky watchdog error, cleared on entry to ONLINE
//   recal_req         : one-cycle pulse on watchdog expiry
//   flush_cnt         : FLUSH entries, saturating (DDR_AVL_GATE_STATS_EN)
//   timeout_cnt       : watchdog expiries, saturating (DDR_AVL_GATE_STATS_EN)
//   dbg_state         : current FSM state
// Optional build macro: DDR_AVL_GATE_STATS_EN enables the event counters;
// without it both counter outputs are tied to zero.
module ddr_avl_gate
  import ddr_avl_gate_pkg::*;
#(
  parameter int ADDR_W   = 25,
  parameter int DATA_W   = 64,
  parameter int BURST_W  = 4,
  parameter int MAX_PEND = 16,
  parameter int TIMEOUT  = 1_000_000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ready,
  ddr_avl_gate_if.slave       bus,
  output logic                online,
  output logic                err_timeout,
  output logic                recal_req,
  output logic [15:0]         flush_cnt,
  output logic [15:0]         timeout_cnt,
  output gate_state_e         dbg_state
);
  localparam int PW = pend_width(MAX_PEND);

  gate_state_e        state_q, state_d;
  logic               rearm_q, rearm_d;
  logic [PW-1:0]      pend_q, pend_d;
  logic [BURST_W-1:0] wr_left_q, wr_left_d;
  logic               err_timeout_q, err_timeout_d;

  logic [PW:0]        pend_sum;
  logic               rd_ok, rd_acc, wr_acc, absorb;
  logic [BURST_W-1:0] burst_m1;
  logic               wd_run, wd_clr, wd_expire;

  // Address, data and size are passed straight through; only the request
  // strobes are gated.
  assign bus.avl_addr  = bus.us_address;
  assign bus.avl_wdata = bus.us_writedata;
  assign bus.avl_be    = bus.us_byteenable;
  assign bus.avl_size  = bus.us_burstcount;

  assign pend_sum = {1'b0, pend_q} + (PW+1)'(bus.us_burstcount);
  assign rd_ok    = pend_sum <= (PW+1)'(MAX_PEND);
  assign burst_m1 = (bus.us_burstcount == '0) ? '0 : bus.us_burstcount - BURST_W'(1);

  assign wd_run = (state_q == ONLINE) && (pend_q != '0);
  assign wd_clr = !wd_run;

  ddr_avl_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (wd_run),
    .kick    (bus.avl_rdata_valid),
    .clr     (wd_clr),
    .expire  (wd_expire)
  );

  always_comb begin
    state_d              = state_q;
    rearm_d              = rearm_q;
    pend_d               = pend_q;
    wr_left_d            = wr_left_q;
    err_timeout_d        = err_timeout_q;
    rd_acc               = 1'b0;
    wr_acc               = 1'b0;
    absorb               = 1'b0;
    bus.us_waitrequest   = 1'b1;
    bus.us_readdata      = FLUSH_DATA[DATA_W-1:0];
    bus.us_readdatavalid = 1'b0;
    bus.us_response_err  = 1'b0;
    bus.avl_read_req     = 1'b0;
    bus.avl_write_req    = 1'b0;

    case (state_q)
      OFFLINE: begin
        if (ready && rearm_q) begin
          state_d       = ONLINE;
          err_timeout_d = 1'b0;
        end
      end
      ONLINE: begin
        bus.avl_read_req     = bus.us_read & rd_ok;
        bus.avl_write_req    = bus.us_write;
        bus.us_waitrequest   = ~bus.avl_ready | (bus.us_read & ~rd_ok);
        bus.us_readdata      = bus.avl_rdata;
        bus.us_readdatavalid = bus.avl_rdata_valid;
        rd_acc = bus.us_read & rd_ok & bus.avl_ready;
        wr_acc = bus.us_write & bus.avl_ready;
        if (rd_acc) pend_d = pend_d + PW'(bus.us_burstcount);
        if (bus.avl_rdata_valid && (pend_q != '0)) pend_d = pend_d - PW'(1);
        // First beat of a burst loads the remaining count; later beats count down.
        if (wr_acc) wr_left_d = (wr_left_q == '0) ? burst_m1 : wr_left_q - BURST_W'(1);
        if (!ready || wd_expire) state_d = FLUSH;
        if (wd_expire) err_timeout_d = 1'b1;
      end
      FLUSH: begin
        // Only the tail of an in-flight write burst is accepted (and dropped).
        absorb             = (wr_left_q != '0) && bus.us_write;
        bus.us_waitrequest = ~absorb;
        if (absorb) wr_left_d = wr_left_q - BURST_W'(1);
        if (pend_q != '0) begin
          bus.us_readdatavalid = 1'b1;
          bus.us_response_err  = 1'b1;
          pend_d               = pend_q - PW'(1);
        end
        // Leave on the cycle the last obligation is met, so k pending
        // reads take exactly k cycles.
        if ((pend_d == '0) && (wr_left_d == '0)) state_d = OFFLINE;
      end
      default: state_d = OFFLINE;
    endcase

    // A ready drop always re-arms, even when it coincides with expiry.
    if (!ready)         rearm_d = 1'b1;
    else if (wd_expire) rearm_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= OFFLINE;
      rearm_q       <= 1'b1;
      pend_q        <= '0;
      wr_left_q     <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rearm_q       <= rearm_d;
      pend_q        <= pend_d;
      wr_left_q     <= wr_left_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign online      = (state_q == ONLINE);
  assign err_timeout = err_timeout_q;
  assign recal_req   = wd_expire;
  assign dbg_state   = state_q;

`ifdef DDR_AVL_GATE_STATS_EN
  logic [15:0] flush_cnt_q, flush_cnt_d, timeout_cnt_q, timeout_cnt_d;

  always_comb begin
    flush_cnt_d   = flush_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    if ((state_q == ONLINE) && (state_d == FLUSH) && (flush_cnt_q != 16'hFFFF))
      flush_cnt_d = flush_cnt_q + 16'd1;
    if (wd_expire && (timeout_cnt_q != 16'hFFFF))
      timeout_cnt_d = timeout_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flush_cnt_q   <= '0;
      timeout_cnt_q <= '0;
    end else begin
      flush_cnt_q   <= flush_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

  assign flush_cnt   = flush_cnt_q;
  assign timeout_cnt = timeout_cnt_q;
`else
  assign flush_cnt   = '0;
  assign timeout_cnt = '0;
`endif

endmodule

// File: tb/tb_ddr_avl_gate.sv
module tb_ddr_avl_gate;
  import ddr_avl_gate_pkg::*;

  localparam int ADDR_W   = 25;
  localparam int DATA_W   = 64;
  localparam int BURST_W  = 4;
  localparam int MAX_PEND = 16;
  localparam int TIMEOUT  = 100;

  logic        clk;
  logic        reset_n;
  logic        ready;
  logic        online;
  logic        err_timeout;
  logic        recal_req;
  logic [15:0] flush_cnt;
  logic [15:0] timeout_cnt;
  gate_state_e dbg_state;

  int checks;
  int errors;
  logic [DATA_W-1:0] exp_q[$];

  ddr_avl_gate_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) bus ();

  ddr_avl_gate #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W),
    .MAX_PEND(MAX_PEND), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ready       (ready),
    .bus         (bus),
    .online      (online),
    .err_timeout (err_timeout),
    .recal_req   (recal_req),
    .flush_cnt   (flush_cnt),
    .timeout_cnt (timeout_cnt),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- table vectors ----------------
  typedef struct {
    logic       rd;
    logic       wr;
    logic [3:0] bc;
    logic       ar;
    logic       rv;
    logic       e_wait;
    logic       e_rreq;
    logic       e_wreq;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(input logic rd, input logic wr, input logic [3:0] bc,
                              input logic ar, input logic rv, input logic e_wait,
                              input logic e_rreq, input logic e_wreq);
    vec_t v;
    v.rd = rd; v.wr = wr; v.bc = bc; v.ar = ar; v.rv = rv;
    v.e_wait = e_wait; v.e_rreq = e_rreq; v.e_wreq = e_wreq;
    return v;
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Inputs are driven 1 time unit after posedge; outputs are sampled at negedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_us();
    bus.us_read         = 1'b0;
    bus.us_write        = 1'b0;
    bus.us_burstcount   = 4'd1;
    bus.us_address      = '0;
    bus.us_writedata    = '0;
    bus.us_byteenable   = '1;
    bus.avl_ready       = 1'b1;
    bus.avl_rdata_valid = 1'b0;
    bus.avl_rdata       = '0;
  endtask

  task automatic go_online(input string tag);
    idle_us();
    ready = 1'b1;
    settle();
    chk1({tag, "_not_yet_online"}, online, 1'b0);
    tick();
    settle();
    chk1({tag, "_online"}, online, 1'b1);
    tick();
  endtask

  // Drop ready with k reads outstanding and expect k consecutive flush beats,
  // while the controller keeps returning (late) beats that must be dropped.
  task automatic drop_and_flush(input int k, input string tag);
    idle_us();
    ready = 1'b0;
    settle();
    chk1({tag, "_drop_cycle_online"}, online, 1'b1);
    tick();
    for (int i = 0; i < k; i++) begin
      bus.avl_rdata_valid = 1'b1;
      bus.avl_rdata       = {$urandom, $urandom} | 64'h1;
      settle();
      chk1({tag, "_flush_rdv"}, bus.us_readdatavalid, 1'b1);
      chk({tag, "_flush_data"}, bus.us_readdata, 64'h0);
      chk1({tag, "_flush_err"}, bus.us_response_err, 1'b1);
      tick();
    end
    if (k == 0) begin
      settle();
      chk1({tag, "_flush_none_rdv"}, bus.us_readdatavalid, 1'b0);
      tick();
    end
    bus.avl_rdata_valid = 1'b1;
    bus.avl_rdata       = 64'hDEAD_BEEF_0000_0001;
    bus.us_read         = 1'b1;
    settle();
    chk1({tag, "_late_beat_dropped"}, bus.us_readdatavalid, 1'b0);
    chk({tag, "_state_offline"}, 64'(dbg_state), 64'(OFFLINE));
    chk1({tag, "_offline_wait"}, bus.us_waitrequest, 1'b1);
    chk1({tag, "_offline_no_rreq"}, bus.avl_read_req, 1'b0);
    tick();
    idle_us();
  endtask

  // ---------------- main sequence ----------------
  logic [DATA_W-1:0] d;
  int seen;
  int m_pend;
  int m_wl;
  logic [3:0] cur_bc;

  initial begin
    checks = 0;
    errors = 0;

    tbl[0]  = mk(1, 0, 4, 1, 0, 0, 1, 0);
    tbl[1]  = mk(1, 0, 4, 1, 0, 0, 1, 0);
    tbl[2]  = mk(1, 0, 4, 1, 0, 0, 1, 0);
    tbl[3]  = mk(1, 0, 4, 1, 0, 0, 1, 0);
    tbl[4]  = mk(1, 0, 4, 1, 0, 1, 0, 0);
    tbl[5]  = mk(1, 0, 4, 1, 1, 1, 0, 0);
    tbl[6]  = mk(1, 0, 4, 1, 0, 1, 0, 0);
    tbl[7]  = mk(0, 0, 1, 1, 1, 0, 0, 0);
    tbl[8]  = mk(0, 0, 1, 1, 1, 0, 0, 0);
    tbl[9]  = mk(1, 0, 4, 1, 1, 1, 0, 0);
    tbl[10] = mk(1, 0, 4, 1, 0, 0, 1, 0);
    tbl[11] = mk(1, 0, 4, 0, 0, 1, 0, 0);
    tbl[12] = mk(0, 1, 1, 0, 0, 1, 0, 1);
    tbl[13] = mk(0, 1, 1, 1, 0, 0, 0, 1);
    tbl[14] = mk(1, 0, 1, 0, 1, 1, 0, 0);
    tbl[15] = mk(1, 0, 1, 1, 1, 0, 1, 0);
    tbl[16] = mk(1, 0, 1, 0, 0, 1, 1, 0);

    // Reset: commands presented during reset must not leak.
    idle_us();
    ready   = 1'b0;
    reset_n = 1'b0;
    bus.us_read  = 1'b1;
    bus.us_write = 1'b1;
    repeat (3) tick();
    settle();
    chk1("rst_waitrequest", bus.us_waitrequest, 1'b1);
    chk1("rst_read_req", bus.avl_read_req, 1'b0);
    chk1("rst_write_req", bus.avl_write_req, 1'b0);
    chk1("rst_rdv", bus.us_readdatavalid, 1'b0);
    chk1("rst_online", online, 1'b0);
    chk1("rst_err_timeout", err_timeout, 1'b0);
    chk1("rst_recal", recal_req, 1'b0);
    chk("rst_flush_cnt", 64'(flush_cnt), 64'h0);
    chk("rst_timeout_cnt", 64'(timeout_cnt), 64'h0);
    chk("rst_state", 64'(dbg_state), 64'(OFFLINE));
    tick();
    reset_n = 1'b1;
    idle_us();
    tick();

    // Bring-up: 4-beat write and 4-beat read pass through.
    go_online("bringup");
    bus.us_burstcount = 4'd4;
    for (int i = 0; i < 4; i++) begin
      bus.us_write      = 1'b1;
      bus.us_address    = 25'h100;
      bus.us_writedata  = {$urandom, $urandom};
      bus.us_byteenable = 8'($urandom);
      d = bus.us_writedata;
      settle();
      chk1("wr4_write_req", bus.avl_write_req, 1'b1);
      chk1("wr4_wait", bus.us_waitrequest, 1'b0);
      chk("wr4_wdata", bus.avl_wdata, d);
      chk("wr4_addr", 64'(bus.avl_addr), 64'h100);
      tick();
    end
    idle_us();
    bus.us_read       = 1'b1;
    bus.us_burstcount = 4'd4;
    bus.us_address    = 25'h200;
    settle();
    chk1("rd4_read_req", bus.avl_read_req, 1'b1);
    chk("rd4_size", 64'(bus.avl_size), 64'd4);
    chk1("rd4_wait", bus.us_waitrequest, 1'b0);
    tick();
    idle_us();
    for (int i = 0; i < 4; i++) begin
      bus.avl_rdata_valid = 1'b1;
      bus.avl_rdata       = {$urandom, $urandom};
      exp_q.push_back(bus.avl_rdata);
      settle();
      chk1("rd4_rdv", bus.us_readdatavalid, 1'b1);
      chk1("rd4_err", bus.us_response_err, 1'b0);
      chk("rd4_data", bus.us_readdata, exp_q.pop_front());
      tick();
    end
    idle_us();

    // Table: pend limit and command path (starts from pend=0).
    for (int i = 0; i < 17; i++) begin
      idle_us();
      bus.us_read       = tbl[i].rd;
      bus.us_write      = tbl[i].wr;
      bus.us_burstcount = tbl[i].bc;
      bus.us_address    = 25'($urandom);
      bus.avl_ready     = tbl[i].ar;
      bus.avl_rdata_valid = tbl[i].rv;
      bus.avl_rdata     = {$urandom, $urandom};
      d = bus.avl_rdata;
      settle();
      chk1($sformatf("tbl%0d_wait", i), bus.us_waitrequest, tbl[i].e_wait);
      chk1($sformatf("tbl%0d_rreq", i), bus.avl_read_req, tbl[i].e_rreq);
      chk1($sformatf("tbl%0d_wreq", i), bus.avl_write_req, tbl[i].e_wreq);
      chk1($sformatf("tbl%0d_rdv", i), bus.us_readdatavalid, tbl[i].rv);
      if (tbl[i].rv) chk($sformatf("tbl%0d_rdata", i), bus.us_readdata, d);
      tick();
    end
    drop_and_flush(15, "tbl_drop");

    // Ready drop with 6 reads outstanding.
    go_online("drop6");
    bus.us_read       = 1'b1;
    bus.us_burstcount = 4'd6;
    settle();
    chk1("drop6_rreq", bus.avl_read_req, 1'b1);
    tick();
    drop_and_flush(6, "drop6");

    // Ready drop mid-write: beat 1 of 8 forwarded, remaining 7 absorbed.
    go_online("midwr");
    bus.us_write      = 1'b1;
    bus.us_burstcount = 4'd8;
    settle();
    chk1("midwr_beat1_wreq", bus.avl_write_req, 1'b1);
    chk1("midwr_beat1_wait", bus.us_waitrequest, 1'b0);
    tick();
    bus.us_write = 1'b0;
    ready        = 1'b0;
    settle();
    tick();
    for (int i = 0; i < 7; i++) begin
      bus.us_write = 1'b1;
      settle();
      chk1($sformatf("midwr_absorb%0d_wait", i), bus.us_waitrequest, 1'b0);
      chk1($sformatf("midwr_absorb%0d_wreq", i), bus.avl_write_req, 1'b0);
      tick();
    end
    settle();
    chk1("midwr_after_wait", bus.us_waitrequest, 1'b1);
    chk("midwr_after_state", 64'(dbg_state), 64'(OFFLINE));
    tick();
    idle_us();

    // Watchdog: single read, no response.
    go_online("wd");
    bus.us_read       = 1'b1;
    bus.us_burstcount = 4'd1;
    settle();
    chk1("wd_rreq", bus.avl_read_req, 1'b1);
    tick();
    idle_us();
    seen = 0;
    for (int c = 1; c <= 200; c++) begin
      settle();
      if (recal_req) begin
        seen = c;
        break;
      end
      tick();
    end
    chk("wd_expire_cycle", 64'(seen), 64'd100);
    tick();
    settle();
    chk1("wd_recal_one_cycle", recal_req, 1'b0);
    chk1("wd_err_timeout", err_timeout, 1'b1);
    chk1("wd_flush_rdv", bus.us_readdatavalid, 1'b1);
    chk1("wd_flush_err", bus.us_response_err, 1'b1);
    chk("wd_flush_data", bus.us_readdata, 64'h0);
    tick();
    settle();
    chk1("wd_single_flush_beat", bus.us_readdatavalid, 1'b0);
    tick();
    repeat (5) tick();
    settle();
    chk1("wd_no_rearm_online", online, 1'b0);
    chk1("wd_err_sticky", err_timeout, 1'b1);
    tick();
    ready = 1'b0;
    tick();
    go_online("wd_rearm");
    settle();
    chk1("wd_err_cleared", err_timeout, 1'b0);
    tick();

`ifdef DDR_AVL_GATE_STATS_EN
    chk("stats_flush_cnt", 64'(flush_cnt), 64'd4);
    chk("stats_timeout_cnt", 64'(timeout_cnt), 64'd1);
`else
    chk("stats_flush_cnt", 64'(flush_cnt), 64'd0);
    chk("stats_timeout_cnt", 64'(timeout_cnt), 64'd0);
`endif

    // Randomized traffic against a word-count reference model.
    m_pend = 0;
    m_wl   = 0;
    cur_bc = 4'd1;
    for (int n = 0; n < 400; n++) begin
      logic rd, wr, ar, rv, e_rd_ok;
      idle_us();
      rd = 1'b0;
      wr = 1'b0;
      if (m_wl > 0) begin
        wr = 1'b1;
      end else begin
        case ($urandom_range(0, 3))
          1, 2: begin rd = 1'b1; cur_bc = 4'($urandom_range(1, 8)); end
          3:    begin wr = 1'b1; cur_bc = 4'($urandom_range(1, 8)); end
          default: ;
        endcase
      end
      ar = ($urandom_range(0, 3) != 0);
      rv = (m_pend > 0) && ($urandom_range(0, 1) == 1);
      bus.us_read         = rd;
      bus.us_write        = wr;
      bus.us_burstcount   = cur_bc;
      bus.us_address      = 25'($urandom);
      bus.avl_ready       = ar;
      bus.avl_rdata_valid = rv;
      bus.avl_rdata       = {$urandom, $urandom};
      if (rv) exp_q.push_back(bus.avl_rdata);
      e_rd_ok = (m_pend + int'(cur_bc)) <= MAX_PEND;
      settle();
      chk1("rnd_wait", bus.us_waitrequest, !ar || (rd && !e_rd_ok));
      chk1("rnd_rreq", bus.avl_read_req, rd && e_rd_ok);
      chk1("rnd_wreq", bus.avl_write_req, wr);
      chk1("rnd_rdv", bus.us_readdatavalid, rv);
      if (bus.us_readdatavalid) begin
        if (exp_q.size() == 0) chk("rnd_rdata_unexpected", bus.us_readdata, 64'h0 - 64'h1);
        else                   chk("rnd_rdata", bus.us_readdata, exp_q.pop_front());
      end
      if (rd && e_rd_ok && ar) m_pend += int'(cur_bc);
      if (rv) m_pend -= 1;
      if (wr && ar) m_wl = (m_wl == 0) ? int'(cur_bc) - 1 : m_wl - 1;
      tick();
    end
    // Finish any open write burst, then drop ready and expect m_pend flush beats.
    for (int i = 0; i < 8 && m_wl > 0; i++) begin
      idle_us();
      bus.us_write      = 1'b1;
      bus.us_burstcount = cur_bc;
      tick();
      m_wl -= 1;
    end
    drop_and_flush(m_pend, "rnd_drop");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ddr_avl_gate.md
# ddr_avl_gate

Traffic gate between the user-side Avalon-MM master and the DDR controller's Avalon port. It consumes the `ready` output of the DDR reset sequencer and blocks commands while memory is not ready. If memory is lost mid-transaction, it completes every outstanding read with flush data, so the user master never hangs. A read-response watchdog raises a recalibration request, which is fed back to the reset sequencer.

## Interface
- `ADDR_W`, 25, word address width
- `DATA_W`, 64, data width; byteenable is `DATA_W/8`
- `BURST_W`, 4, burstcount width; a burst is 1..`2**(BURST_W-1)` words
- `MAX_PEND`, 16, maximum outstanding read words; must be ≥ `2**(BURST_W-1)`
- `TIMEOUT`, 1_000_000, number of clk cycles without a read beat while reads are pending before a timeout is declared
- `clk`  in  1  single clock; all ports are synchronous to it
- `reset_n`  in  1  asynchronous, active-low reset
- `ready`  in  1  memory-ready from the reset sequencer; synchronous to `clk`
- `us_address`, `us_read`, `us_write`, `us_writedata`, `us_byteenable`, `us_burstcount`  in  `ADDR_W`/1/1/`DATA_W`/`DATA_W/8`/`BURST_W`  user command
- `us_waitrequest`  out  1  stall to the user master
- `us_readdata`  out  `DATA_W`  read data to the user master
- `us_readdatavalid`  out  1  read beat valid to the user master
- `us_response_err`  out  1  set with each flushed (synthesized) read beat
- `avl_addr`, `avl_read_req`, `avl_write_req`, `avl_wdata`, `avl_be`, `avl_size`  out  widths as above  command to the controller
- `avl_ready`  in  1  controller accepts the current command or write beat
- `avl_rdata`  in  `DATA_W`  read data from the controller
- `avl_rdata_valid`  in  1  read beat valid from the controller
- `online`  out  1  high only in ONLINE
- `err_timeout`  out  1  sticky; cleared on the next entry to ONLINE
- `recal_req`  out  1  one-cycle pulse on watchdog expiry
- `flush_cnt`, `timeout_cnt`  out  16 each  event counters; see Configuration

## Operation
- States:
  - OFFLINE: `us_waitrequest`=1; no `avl_*` requests are driven.
  - ONLINE: commands pass through to the controller.
  - FLUSH: traffic is drained and outstanding reads are completed with flush data.
- OFFLINE→ONLINE: when `ready`=1 and `rearm`=1.
  - `rearm` is set whenever `ready`=0 in any state.
  - `rearm` is cleared on watchdog expiry.
- ONLINE→FLUSH: on `ready`=0 or watchdog expiry.
- FLUSH→OFFLINE: when `pend`=0 and the write burst counter is 0.
- ONLINE command path is combinational:
  - `avl_read_req` = `us_read` & `rd_ok`, where `rd_ok` = (`pend` + `us_burstcount` ≤ `MAX_PEND`).
  - `us_waitrequest` = ~`avl_ready` | (`us_read` & ~`rd_ok`).
- `pend` accounting: increments by `us_burstcount` on an accepted read and decrements by 1 per `avl_rdata_valid`. On a simultaneous accept and beat, `pend` changes by burstcount−1. `pend` never exceeds `MAX_PEND` and never underflows.
- Write bursts: `wr_left` is loaded with burstcount−1 on the first accepted beat and decrements on each subsequent beat.
  - In FLUSH, remaining write beats are absorbed with `us_waitrequest`=0 and are never forwarded.
  - New commands in FLUSH are stalled.
- FLUSH reads: each cycle with `pend`>0, drive `us_readdatavalid`=1, `us_readdata`=`FLUSH_DATA` (all zeros) and `us_response_err`=1, then decrement `pend`. Controller beats arriving in FLUSH or OFFLINE are dropped.
- Watchdog:
  - Counts while `pend`>0 in ONLINE; cleared on each `avl_rdata_valid` and whenever `pend`=0.
  - Expires when the count reaches `TIMEOUT`−1. Expiry pulses `recal_req`, sets `err_timeout`, clears `rearm` and enters FLUSH.
- Simultaneous `ready`=0 and watchdog expiry: enter FLUSH, `recal_req` pulses, and `rearm` ends set.

## Timing
- Values during reset: state=OFFLINE, `rearm`=1, `pend`=0, `wr_left`=0.
- Outputs during reset: `us_waitrequest`=1, all `avl_*` requests=0, `us_readdatavalid`=0, `online`=0, `err_timeout`=0, `recal_req`=0, counters=0.
- ONLINE read path: `us_readdata`/`us_readdatavalid` follow `avl_rdata`/`avl_rdata_valid` with 0 cycles of latency.
- OFFLINE→ONLINE: `online` rises 1 cycle after `ready` is sampled high.
- A `ready` drop is sampled at clock edge N: FLUSH is entered at N; the first flush beat appears in cycle N+1; one flush beat is issued per cycle.
- Flushing `pend`=k takes exactly k cycles, after which the block is in OFFLINE.

## Configuration
- `DDR_AVL_GATE_STATS_EN` defined:
  - `flush_cnt` counts FLUSH entries; saturates at 0xFFFF.
  - `timeout_cnt` counts watchdog expiries; saturates at 0xFFFF.
  - Both are cleared only by reset.
- Macro undefined: both outputs are tied to 0 and no counter logic is built.

## Structure
- Package `ddr_avl_gate_pkg` holds:
  - the state enum (OFFLINE, ONLINE, FLUSH)
  - `FLUSH_DATA`
  - the width of `pend`: `$clog2(MAX_PEND+1)`
- Sub-module `ddr_avl_watchdog` implements the timer, with inputs `run`, `kick` and `clr` and a one-cycle `expire` output.

## Test plan
- **Bring-up:** reset, then `ready`=1 → `online`=1 on the next cycle. A 4-beat write and a 4-beat read pass through unchanged; `pend` returns to 0.
- **Pend limit:** issue 4 reads of burstcount 4 with no returns, then a fifth read → `us_waitrequest`=1. After one beat returns, the fifth read is still stalled; after 4 beats return, it is accepted.
- **Ready drop with reads outstanding:** `pend`=6 when `ready`→0 → exactly 6 beats with `us_readdata`=0 and `us_response_err`=1 on consecutive cycles, then OFFLINE. Late controller beats are not forwarded.
- **Ready drop mid-write:** `ready` drops after beat 1 of an 8-beat write → 7 beats are absorbed with `us_waitrequest`=0; `avl_write_req` stays 0.
- **Watchdog:** `TIMEOUT`=100, one read with no response → `recal_req` pulses at cycle 100, `err_timeout`=1, one flush beat is issued. ONLINE is not re-entered until `ready` goes 0 and then back to 1.
- **Statistics (`DDR_AVL_GATE_STATS_EN`):** 3 ready drops plus 1 timeout → `flush_cnt`=4, `timeout_cnt`=1. Without the macro, both counters read 0.
